// File: rtl/dh_pkg.sv
// Shared definitions for the DH decryption block: FSM states, default width,
// and the fixed accept-to-result latency used by benches.
package dh_pkg;

    localparam int unsigned DH_W = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXP_KEY = 3'd1,
        EXP_INV = 3'd2,
        MUL_MSG = 3'd3,
        DONE    = 3'd4
    } dh_state_e;

    // Cycles from accept edge to out_valid for a job that runs to completion.
    function automatic int unsigned lat(input int unsigned w);
        return (4 * w + 1) * (w + 1) + 1;
    endfunction

endpackage

// File: rtl/dh_modmul_serial.sv
// Serial interleaved modular multiplier: y = a*b mod p, one bit of b per cycle,
// MSB first. Requires a, b < p and p < 2^(W-1). done pulses exactly W+1 cycles
// after the start cycle; y holds the result until the next start.
module dh_modmul_serial #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] p,
    output logic         done,
    output logic [W-1:0] y
);

    localparam int unsigned IW = W + 2;
    localparam int unsigned CW = $clog2(W + 1);

    logic [IW-1:0] acc_q, acc_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [W-1:0]  p_q, p_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [IW-1:0] pw;
    logic [IW-1:0] sum;
    logic [IW-1:0] red1;
    logic [IW-1:0] red2;

    // One Horner step: double, add a if the current b bit is set, then reduce twice.
    always_comb begin
        pw   = IW'(p_q);
        sum  = (acc_q << 1) + (b_q[W-1] ? IW'(a_q) : IW'(0));
        red1 = (sum >= pw) ? (sum - pw) : sum;
        red2 = (red1 >= pw) ? (red1 - pw) : red1;
    end

    // Next-state: load on start, otherwise iterate while busy.
    always_comb begin
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        p_d    = p_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            acc_d  = '0;
            a_d    = a;
            b_d    = b;
            p_d    = p;
            cnt_d  = CW'(W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            acc_d = red2;
            b_d   = b_q << 1;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            p_q    <= p_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign done = done_q;
    assign y    = W'(acc_q);

endmodule

// File: rtl/dh_decrypt.sv
// DH receiver: K = r_peer^x mod p, K^-1 = K^(p-2) mod p, m = c*K^-1 mod p.
// One time-shared serial multiplier; every multiply is chained back to back so
// the accept-to-result latency is fixed at (4W+1)(W+1)+1 cycles.
// Optional macro DH_KEY_OUT_EN adds output port key carrying the derived K.
module dh_decrypt
    import dh_pkg::*;
#(
    parameter int unsigned W = DH_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] p,
    input  logic [W-1:0] x,
    input  logic [W-1:0] r_peer,
    input  logic [W-1:0] c,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] m,
    output logic         err
`ifdef DH_KEY_OUT_EN
    ,
    output logic [W-1:0] key
`endif
);

    localparam int unsigned BW = (W > 1) ? $clog2(W) : 1;

    dh_state_e     state_q, state_d;
    logic [W-1:0]  p_q, p_d;
    logic [W-1:0]  x_q, x_d;
    logic [W-1:0]  r_q, r_d;
    logic [W-1:0]  c_q, c_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  k_q, k_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          sq_q, sq_d;
    logic          first_q, first_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [W-1:0]  m_q, m_d;
    logic          err_q, err_d;
`ifdef DH_KEY_OUT_EN
    logic [W-1:0]  key_q, key_d;
`endif

    logic          mm_start;
    logic [W-1:0]  mm_a;
    logic [W-1:0]  mm_b;
    logic          mm_done;
    logic [W-1:0]  mm_y;

    logic          rng_bad;
    logic          in_exp_inv;
    logic [W-1:0]  exp_e;
    logic [W-1:0]  exp_base;
    logic [W-1:0]  acc_upd;
    logic          go_done;
    logic [W-1:0]  done_m;
    logic          done_err;

    dh_modmul_serial #(
        .W (W)
    ) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mm_start),
        .a     (mm_a),
        .b     (mm_b),
        .p     (p_q),
        .done  (mm_done),
        .y     (mm_y)
    );

    // Operand range check on the captured job.
    always_comb begin
        rng_bad = (p_q < W'(3)) | p_q[W-1] | (r_q >= p_q) | (c_q >= p_q);
    end

    // Next-state, multiplier sequencing and output updates.
    always_comb begin
        state_d     = state_q;
        p_d         = p_q;
        x_d         = x_q;
        r_d         = r_q;
        c_d         = c_q;
        acc_d       = acc_q;
        k_d         = k_q;
        bit_d       = bit_q;
        sq_d        = sq_q;
        first_d     = first_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        m_d         = m_q;
        err_d       = err_q;
        mm_start    = 1'b0;
        mm_a        = '0;
        mm_b        = '0;
        go_done     = 1'b0;
        done_m      = '0;
        done_err    = 1'b0;

        in_exp_inv = (state_q == EXP_INV);
        exp_e      = in_exp_inv ? (p_q - W'(2)) : x_q;
        exp_base   = in_exp_inv ? k_q : r_q;
        acc_upd    = exp_e[bit_q] ? mm_y : acc_q;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    p_d        = p;
                    x_d        = x;
                    r_d        = r_peer;
                    c_d        = c;
                    acc_d      = W'(1);
                    bit_d      = BW'(W - 1);
                    sq_d       = 1'b1;
                    first_d    = 1'b1;
                    in_ready_d = 1'b0;
                    state_d    = EXP_KEY;
                end
            end
            EXP_KEY, EXP_INV: begin
                if (first_q) begin
                    // First cycle after accept: kick off the first square unless the job is bad.
                    first_d = 1'b0;
                    if (!rng_bad) begin
                        mm_start = 1'b1;
                        mm_a     = acc_q;
                        mm_b     = acc_q;
                    end
                end else if (rng_bad && (state_q == EXP_KEY)) begin
                    go_done  = 1'b1;
                    done_err = 1'b1;
                end else if (mm_done) begin
                    if (sq_q) begin
                        // Square finished: always follow with the multiply by base.
                        acc_d    = mm_y;
                        mm_start = 1'b1;
                        mm_a     = exp_base;
                        mm_b     = mm_y;
                        sq_d     = 1'b0;
                    end else if (bit_q != BW'(0)) begin
                        acc_d    = acc_upd;
                        bit_d    = bit_q - BW'(1);
                        mm_start = 1'b1;
                        mm_a     = acc_upd;
                        mm_b     = acc_upd;
                        sq_d     = 1'b1;
                    end else if (state_q == EXP_KEY) begin
                        if (acc_upd == '0) begin
                            go_done  = 1'b1;
                            done_err = 1'b1;
                        end else begin
                            // Hand straight over to the inversion with no idle cycle.
                            k_d      = acc_upd;
                            acc_d    = W'(1);
                            bit_d    = BW'(W - 1);
                            sq_d     = 1'b1;
                            mm_start = 1'b1;
                            mm_a     = W'(1);
                            mm_b     = W'(1);
                            state_d  = EXP_INV;
                        end
                    end else begin
                        acc_d    = acc_upd;
                        mm_start = 1'b1;
                        mm_a     = c_q;
                        mm_b     = acc_upd;
                        state_d  = MUL_MSG;
                    end
                end
            end
            MUL_MSG: begin
                if (mm_done) begin
                    go_done = 1'b1;
                    done_m  = mm_y;
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_done) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            m_d         = done_m;
            err_d       = done_err;
            k_d         = '0;
        end
    end

`ifdef DH_KEY_OUT_EN
    // Key output follows the result; zero on any error.
    always_comb begin
        key_d = key_q;
        if (go_done) begin
            key_d = done_err ? '0 : k_q;
        end
    end
`endif

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            p_q         <= '0;
            x_q         <= '0;
            r_q         <= '0;
            c_q         <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            bit_q       <= '0;
            sq_q        <= 1'b0;
            first_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            m_q         <= '0;
            err_q       <= 1'b0;
`ifdef DH_KEY_OUT_EN
            key_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            x_q         <= x_d;
            r_q         <= r_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            bit_q       <= bit_d;
            sq_q        <= sq_d;
            first_q     <= first_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            m_q         <= m_d;
            err_q       <= err_d;
`ifdef DH_KEY_OUT_EN
            key_q       <= key_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign m         = m_q;
    assign err       = err_q;
`ifdef DH_KEY_OUT_EN
    assign key       = key_q;
`endif

endmodule
